// File: rtl/fifos_to_axis_rr_arbiter.sv
// Round-robin drain of NUM_FIFOS read ports onto one AXI4-Stream master.
// Bursts of up to BURST_LEN beats per grant, source index on tdest.
module fifos_to_axis_rr_arbiter #(
  parameter int NUM_FIFOS  = 4,
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            en,
  input  logic [NUM_FIFOS-1:0]            fifo_empty,
  output logic [NUM_FIFOS-1:0]            fifo_rena,
  input  logic [NUM_FIFOS*DATA_WIDTH-1:0] fifo_rdata,
  output logic [DATA_WIDTH-1:0]           m_axis_tdata,
  output logic                            m_axis_tvalid,
  input  logic                            m_axis_tready,
  output logic                            m_axis_tlast,
  output logic [$clog2(NUM_FIFOS)-1:0]    m_axis_tdest,
  output logic                            busy
);

  localparam int IDX_W = $clog2(NUM_FIFOS);
  localparam int CNT_W = $clog2(BURST_LEN + 1);
  localparam logic [CNT_W-1:0] BL    = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0] BL_M1 = CNT_W'(BURST_LEN - 1);
  localparam logic [IDX_W:0]   NF    = (IDX_W+1)'(NUM_FIFOS);

  typedef enum logic [1:0] {IDLE, BURST, WAIT_LAST} state_t;

  state_t state, state_nx;
  logic [IDX_W-1:0] grant, grant_nx;
  logic [IDX_W-1:0] last_grant, last_grant_nx;
  logic [IDX_W-1:0] pick, cand;
  logic [IDX_W:0]   sum;
  logic             found;
  logic [CNT_W-1:0] issued, issued_nx;
  logic             inflight, rd, pop, cap_last;
  logic [2:0]       occ;
  logic [1:0]       buf_cnt;
  logic [DATA_WIDTH-1:0] d0, d1, cap_data;
  logic             l0, l1;
  logic [IDX_W-1:0] t0, t1;
  logic [DATA_WIDTH-1:0] rdata_a [NUM_FIFOS];

  for (genvar i = 0; i < NUM_FIFOS; i++) begin : g_unpack
    assign rdata_a[i] = fifo_rdata[i*DATA_WIDTH +: DATA_WIDTH];
  end

  assign m_axis_tvalid = buf_cnt != 2'd0;
  assign m_axis_tdata  = d0;
  assign m_axis_tlast  = l0;
  assign m_axis_tdest  = t0;
  assign busy          = (state != IDLE) || (buf_cnt != 2'd0);

  assign pop      = m_axis_tvalid && m_axis_tready;
  assign occ      = {1'b0, buf_cnt} + {2'b0, inflight} - {2'b0, pop};
  assign cap_data = rdata_a[grant];
  assign cap_last = (issued == BL) || fifo_empty[grant];
  assign fifo_rena = rd ? (NUM_FIFOS'(1) << grant) : '0;

  // first non-empty index after last_grant, wrapping
  always_comb begin
    found = 1'b0;
    pick  = '0;
    sum   = '0;
    cand  = '0;
    for (int k = 1; k <= NUM_FIFOS; k++) begin
      sum = {1'b0, last_grant} + (IDX_W+1)'(k);
      if (sum >= NF) sum = sum - NF;
      cand = sum[IDX_W-1:0];
      if (!found && !fifo_empty[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_nx      = state;
    grant_nx      = grant;
    last_grant_nx = last_grant;
    issued_nx     = issued;
    rd            = 1'b0;
    unique case (state)
      IDLE: begin
        if (en && found) begin
          grant_nx  = pick;
          issued_nx = '0;
          state_nx  = BURST;
        end
      end
      BURST: begin
        rd = !fifo_empty[grant] && (issued != BL) && (occ < 3'd2);
        if (rd) issued_nx = issued + 1'b1;
        // an empty source at capture closes the burst early
        if (inflight && cap_last) begin
          state_nx      = IDLE;
          last_grant_nx = grant;
        end else if (rd && issued == BL_M1) begin
          state_nx = WAIT_LAST;
        end else if (fifo_empty[grant] && !inflight) begin
          state_nx      = IDLE;
          last_grant_nx = grant;
        end
      end
      WAIT_LAST: begin
        if (inflight) begin
          state_nx      = IDLE;
          last_grant_nx = grant;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= IDX_W'(NUM_FIFOS - 1);
      issued     <= '0;
      inflight   <= 1'b0;
    end else begin
      state      <= state_nx;
      grant      <= grant_nx;
      last_grant <= last_grant_nx;
      issued     <= issued_nx;
      inflight   <= rd;
    end
  end

  // two-entry output buffer, entry 0 is the head
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_cnt <= 2'd0;
      d0 <= '0; l0 <= 1'b0; t0 <= '0;
      d1 <= '0; l1 <= 1'b0; t1 <= '0;
    end else begin
      unique case (buf_cnt)
        2'd0: begin
          if (inflight) begin
            d0 <= cap_data; l0 <= cap_last; t0 <= grant;
            buf_cnt <= 2'd1;
          end
        end
        2'd1: begin
          if (inflight && pop) begin
            d0 <= cap_data; l0 <= cap_last; t0 <= grant;
          end else if (inflight) begin
            d1 <= cap_data; l1 <= cap_last; t1 <= grant;
            buf_cnt <= 2'd2;
          end else if (pop) begin
            buf_cnt <= 2'd0;
          end
        end
        default: begin
          if (pop) begin
            d0 <= d1; l0 <= l1; t0 <= t1;
            if (inflight) begin
              d1 <= cap_data; l1 <= cap_last; t1 <= grant;
            end else begin
              buf_cnt <= 2'd1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifos_to_axis_rr_arbiter.sv
// Bench for fifos_to_axis_rr_arbiter: FIFO bank model, stream monitor,
// and a queue-level round-robin reference computed from preloaded contents.
module tb_fifos_to_axis_rr_arbiter;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int BL = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic m_axis_tready = 1'b0;
  logic [N-1:0] fifo_empty, fifo_rena;
  logic [N*W-1:0] fifo_rdata;
  logic [W-1:0] m_axis_tdata;
  logic m_axis_tvalid, m_axis_tlast, busy;
  logic [1:0] m_axis_tdest;

  fifos_to_axis_rr_arbiter #(.NUM_FIFOS(N), .DATA_WIDTH(W), .BURST_LEN(BL)) dut (
    .clk(clk), .rst(rst), .en(en),
    .fifo_empty(fifo_empty), .fifo_rena(fifo_rena), .fifo_rdata(fifo_rdata),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
    .m_axis_tdest(m_axis_tdest), .busy(busy)
  );

  always #5 clk = ~clk;

  // FIFO bank model
  logic [W-1:0] mem [N][256];
  int wp [N] = '{default: 0};
  int rp [N] = '{default: 0};
  logic [W-1:0] rdata_r [N] = '{default: '0};
  int bad_rd = 0;

  for (genvar gi = 0; gi < N; gi++) begin : g_fifo
    assign fifo_empty[gi] = (rp[gi] == wp[gi]);
    assign fifo_rdata[gi*W +: W] = rdata_r[gi];
  end

  always @(posedge clk) begin
    if ($countones(fifo_rena) > 1) bad_rd <= bad_rd + 1;
    for (int i = 0; i < N; i++) begin
      if (fifo_rena[i]) begin
        if (rp[i] == wp[i]) bad_rd <= bad_rd + 1;
        else begin
          rdata_r[i] <= mem[i][rp[i]];
          rp[i] <= rp[i] + 1;
        end
      end
    end
  end

  function automatic int sum_rp();
    int s = 0;
    for (int i = 0; i < N; i++) s += rp[i];
    return s;
  endfunction

  // stream monitor
  logic [W-1:0] obs_d [1024];
  logic obs_l [1024];
  logic [1:0] obs_t [1024];
  int obs_c [1024];
  int obs_n = 0, cyc = 0, stab_err = 0, ovf_err = 0, off = 0;
  logic pv = 1'b0, pl = 1'b0;
  logic [W-1:0] pd = '0;
  logic [1:0] pt = '0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rst) begin
      pv <= 1'b0;
      off <= sum_rp() - obs_n;
    end else begin
      if (sum_rp() - obs_n - off > 2) ovf_err <= ovf_err + 1;
      if (pv && (!m_axis_tvalid || m_axis_tdata !== pd ||
                 m_axis_tlast !== pl || m_axis_tdest !== pt))
        stab_err <= stab_err + 1;
      pv <= m_axis_tvalid && !m_axis_tready;
      pd <= m_axis_tdata;
      pl <= m_axis_tlast;
      pt <= m_axis_tdest;
      if (m_axis_tvalid && m_axis_tready) begin
        obs_d[obs_n] <= m_axis_tdata;
        obs_l[obs_n] <= m_axis_tlast;
        obs_t[obs_n] <= m_axis_tdest;
        obs_c[obs_n] <= cyc;
        obs_n <= obs_n + 1;
      end
    end
  end

  int checks = 0, errors = 0;
  int model_last = N - 1;
  logic [W-1:0] exp_d [1024];
  logic exp_l [1024];
  int exp_t [1024];
  int exp_n = 0;

  task automatic load(input int f, input int n);
    for (int j = 0; j < n; j++) mem[f][wp[f] + j] = $urandom;
    wp[f] = wp[f] + n;
  endtask

  // reference: visit sources in rotating order, take min(remaining, BL)
  task automatic build_expected(output int lg_end);
    int r [N];
    int lg, f, b;
    bit any;
    for (int i = 0; i < N; i++) r[i] = rp[i];
    lg = model_last;
    exp_n = 0;
    do begin
      any = 0;
      for (int k = 1; k <= N; k++) begin
        f = (lg + k) % N;
        if (!any && wp[f] > r[f]) begin
          any = 1;
          b = wp[f] - r[f];
          if (b > BL) b = BL;
          for (int j = 0; j < b; j++) begin
            exp_d[exp_n] = mem[f][r[f] + j];
            exp_l[exp_n] = (j == b - 1);
            exp_t[exp_n] = f;
            exp_n++;
          end
          r[f] += b;
          lg = f;
        end
      end
    end while (any);
    lg_end = lg;
  endtask

  task automatic tick(input int mode);
    @(posedge clk);
    #1;
    case (mode)
      0: m_axis_tready = 1'b1;
      1: m_axis_tready = !m_axis_tready;
      2: m_axis_tready = 1'($urandom_range(0, 1));
      default: ;
    endcase
  endtask

  task automatic cmp_beats(input string name, input int base, input int n);
    for (int i = 0; i < n; i++) begin
      checks++;
      if (obs_d[base+i] !== exp_d[i] || obs_l[base+i] !== exp_l[i] ||
          int'(obs_t[base+i]) != exp_t[i]) begin
        errors++;
        $display("FAIL %s beat %0d: got data %h last %0d dest %0d, required %h %0d %0d",
                 name, i, obs_d[base+i], obs_l[base+i], obs_t[base+i],
                 exp_d[i], exp_l[i], exp_t[i]);
      end
    end
  endtask

  task automatic run_compare(input string name, input int mode, output int base);
    int lg, t, got;
    base = obs_n;
    build_expected(lg);
    en = 1'b1;
    t = 0;
    while (obs_n - base < exp_n && t < 3000) begin tick(mode); t++; end
    t = 0;
    while (busy && t < 200) begin tick(mode); t++; end
    repeat (5) tick(0);
    en = 1'b0;
    got = obs_n - base;
    checks++;
    if (got != exp_n) begin
      errors++;
      $display("FAIL %s count: got %0d beats, required %0d", name, got, exp_n);
    end
    cmp_beats(name, base, (got < exp_n) ? got : exp_n);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s idle: busy %0d, required 0", name, busy);
    end
    checks++;
    if (bad_rd != 0 || ovf_err != 0 || stab_err != 0) begin
      errors++;
      $display("FAIL %s rules: bad_rd %0d ovf %0d unstable %0d, required 0 0 0",
               name, bad_rd, ovf_err, stab_err);
    end
    model_last = lg;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; m_axis_tready = 1'b0;
    repeat (3) tick(3);
    checks += 6;
    if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL rst tvalid: got %0d, required 0", m_axis_tvalid); end
    if (m_axis_tlast !== 1'b0) begin errors++; $display("FAIL rst tlast: got %0d, required 0", m_axis_tlast); end
    if (m_axis_tdata !== '0) begin errors++; $display("FAIL rst tdata: got %h, required 0", m_axis_tdata); end
    if (m_axis_tdest !== '0) begin errors++; $display("FAIL rst tdest: got %0d, required 0", m_axis_tdest); end
    if (fifo_rena !== '0) begin errors++; $display("FAIL rst rena: got %b, required 0", fifo_rena); end
    if (busy !== 1'b0) begin errors++; $display("FAIL rst busy: got %0d, required 0", busy); end
    rst = 1'b0;
    model_last = N - 1;
    tick(3);
  endtask

  task automatic test_single();
    int b;
    load(0, 3);
    run_compare("single", 0, b);
    checks++;
    if (obs_c[b+1] - obs_c[b] != 1 || obs_c[b+2] - obs_c[b+1] != 1) begin
      errors++;
      $display("FAIL single spacing: got cycles %0d %0d %0d, required consecutive",
               obs_c[b], obs_c[b+1], obs_c[b+2]);
    end
    checks++;
    if (obs_t[b] !== 2'd0 || obs_l[b+1] !== 1'b0 || obs_l[b+2] !== 1'b1) begin
      errors++;
      $display("FAIL single tags: got dest %0d last %0d/%0d, required 0 0/1",
               obs_t[b], obs_l[b+1], obs_l[b+2]);
    end
  endtask

  task automatic test_sparse();
    int b, r0, r2;
    r0 = rp[0]; r2 = rp[2];
    load(1, 2); load(3, 2);
    run_compare("sparse", 0, b);
    checks++;
    if (obs_t[b] !== 2'd1 || obs_t[b+2] !== 2'd3 || obs_l[b+1] !== 1'b1 || obs_l[b+3] !== 1'b1) begin
      errors++;
      $display("FAIL sparse order: got dest %0d,%0d last %0d,%0d, required 1,3 1,1",
               obs_t[b], obs_t[b+2], obs_l[b+1], obs_l[b+3]);
    end
    checks++;
    if (rp[0] != r0 || rp[2] != r2) begin
      errors++;
      $display("FAIL sparse idle_src: got reads %0d %0d, required 0 0", rp[0] - r0, rp[2] - r2);
    end
  endtask

  task automatic test_all(input string name, input int mode);
    int b;
    for (int f = 0; f < N; f++) load(f, 20);
    run_compare(name, mode, b);
    checks++;
    if (obs_l[b+7] !== 1'b1 || obs_t[b+8] !== 2'd1 || obs_t[b] !== 2'd0) begin
      errors++;
      $display("FAIL %s burst: got dest %0d/%0d last7 %0d, required 0/1 1",
               name, obs_t[b], obs_t[b+8], obs_l[b+7]);
    end
  endtask

  task automatic test_random();
    int b;
    for (int r = 0; r < 3; r++) begin
      for (int f = 0; f < N; f++) load(f, $urandom_range(0, 12));
      run_compare("random", 2, b);
    end
  endtask

  task automatic test_en_drop();
    int b, lg, t, s;
    for (int f = 0; f < N; f++) load(f, 10);
    b = obs_n;
    build_expected(lg);
    m_axis_tready = 1'b1;
    en = 1'b1;
    t = 0;
    while (obs_n - b < 3 && t < 200) begin @(negedge clk); #1; t++; end
    en = 1'b0;
    while (obs_n - b < BL && t < 400) begin @(negedge clk); #1; t++; end
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL en_drop busy_before: got %0d, required 1", busy);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL en_drop busy_after: got %0d, required 0", busy);
    end
    s = sum_rp();
    repeat (20) tick(0);
    checks++;
    if (sum_rp() != s || obs_n - b != BL) begin
      errors++;
      $display("FAIL en_drop halt: got reads %0d beats %0d, required 0 %0d",
               sum_rp() - s, obs_n - b, BL);
    end
    cmp_beats("en_drop", b, BL);
    model_last = exp_t[BL-1];
    run_compare("en_drop_rest", 0, b);
  endtask

  task automatic test_reset_mid();
    int b;
    m_axis_tready = 1'b0;
    load(0, 20);
    en = 1'b1;
    repeat (10) tick(3);
    for (int f = 1; f < N; f++) load(f, 5);
    checks++;
    if (m_axis_tvalid !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid held: tvalid %0d, required 1", m_axis_tvalid);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    en = 1'b0;
    #1;
    checks++;
    if (m_axis_tvalid !== 1'b0 || fifo_rena !== '0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid async: tvalid %0d rena %b busy %0d, required 0 0 0",
               m_axis_tvalid, fifo_rena, busy);
    end
    tick(3);
    rst = 1'b0;
    model_last = N - 1;
    tick(3);
    run_compare("rst_mid", 0, b);
    checks++;
    if (obs_t[b] !== 2'd0) begin
      errors++;
      $display("FAIL rst_mid first: got dest %0d, required 0", obs_t[b]);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_sparse();
    test_all("all_ready", 0);
    test_all("toggle", 1);
    test_random();
    test_en_drop();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
